multicycle_alu: RTL
===================

MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits (legal range 8..64, power of two).
REQ-002 Parameter: SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 Port: clk, input, 1, single clock; all state changes on rising edge.
REQ-004 Port: rst, input, 1, asynchronous active-high reset.
REQ-005 Port: in_valid, input, 1, operation request.
REQ-006 Port: in_ready, output, 1, block can accept a request.
REQ-007 Port: funct, input, 6, operation code.
REQ-008 Port: data1, input, WIDTH, operand A (shift source, dividend, minuend).
REQ-009 Port: data2, input, WIDTH, operand B.
REQ-010 Port: shamt, input, SHW, immediate shift amount.
REQ-011 Port: out_valid, output, 1, result available.
REQ-012 Port: out_ready, input, 1, consumer takes result.
REQ-013 Port: result_lo, output, WIDTH, primary result, product low half, or quotient.
REQ-014 Port: result_hi, output, WIDTH, product high half or remainder; 0 for other ops.
REQ-015 Port: zero, output, 1, high when result_lo == 0 while out_valid is high; 0 otherwise.

Function
REQ-016 Op codes are fixed: ADDU 6'b001001, SUBU 6'b001010, SLL 6'b100001, SLLV 6'b110101, SLTI 6'b101010, MULTU 6'b011001, DIVU 6'b011011.
REQ-017 ADDU/SUBU: result_lo = data1 +/- data2 modulo 2^WIDTH; no overflow flag.
REQ-018 SLL uses shamt; SLLV uses data2[SHW-1:0]; both fill with zeros.
REQ-019 SLTI: result_lo = 1 if data1 < data2 (unsigned), else 0.
REQ-020 Unknown funct: accepted, result_lo = result_hi = 0, single-cycle latency.
REQ-021 FSM states are IDLE, BUSY and DONE; in_ready = (state == IDLE).
REQ-022 A request is accepted on a rising edge with in_valid && in_ready; operands and funct are registered at that edge and later input changes are ignored.
REQ-023 Single-cycle ops: IDLE->DONE at the acceptance edge; out_valid is high in the next cycle (latency 1).
REQ-024 MULTU/DIVU: IDLE->BUSY at acceptance; a counter runs exactly WIDTH iterations, one per edge; the last iteration edge goes BUSY->DONE; out_valid is high WIDTH+1 cycles after acceptance.
REQ-025 MULTU: unsigned shift-add; {result_hi,result_lo} = 2*WIDTH-bit product.
REQ-026 DIVU: unsigned restoring divide; result_lo = quotient, result_hi = remainder.
REQ-027 DIVU with data2 == 0: result_lo = all ones, result_hi = data1, same latency as normal DIVU.
REQ-028 DONE holds out_valid and results stable until out_ready is sampled high; DONE->IDLE on that edge.
REQ-029 in_valid during BUSY or DONE is ignored; no request is queued.
REQ-030 Results are registered, with no combinational path from inputs to outputs, and hold their last value in IDLE; zero is gated by out_valid.

Reset
REQ-031 rst high asynchronously forces state to IDLE, the counter to 0, out_valid to 0, result_lo and result_hi to 0, and zero to 0.
REQ-032 rst during BUSY aborts the operation; no out_valid follows; in_ready = 1 on the first edge after rst is released.

Verification
REQ-033 ADDU data1=0xFFFFFFFF, data2=1 -> one cycle later out_valid=1, result_lo=0, zero=1.
REQ-034 MULTU data1=0xFFFFFFFF, data2=0xFFFFFFFF, WIDTH=32 -> out_valid after 33 cycles, result_hi=0xFFFFFFFE, result_lo=0x00000001; in_ready=0 throughout.
REQ-035 DIVU 100/7 -> result_lo=14, result_hi=2; DIVU 5/0 -> result_lo=0xFFFFFFFF, result_hi=5.
REQ-036 SLL data1=1, shamt=31 -> 0x80000000; SLLV data1=1, data2=0x23 -> 0x8 (low 5 bits only); SLTI 3<5 -> 1.
REQ-037 out_ready held low 10 cycles after a SUBU 5-5 result -> out_valid, result_lo=0 and zero=1 stay stable; a new in_valid is ignored until out_ready is high.
REQ-038 rst pulsed at BUSY cycle 10 of a MULTU -> outputs are 0 immediately; a subsequent ADDU 2+3 returns 5 with latency 1.

Source files
------------

// File: rtl/multicycle_alu.sv
// Multi-cycle integer ALU: single-cycle add/sub/shift/compare plus
// iterative unsigned multiply (shift-add) and divide (restoring).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, in_ready high
// BUSY  | MULTU/DIVU iterating, one step per edge, WIDTH steps total
// DONE  | result held on outputs until out_ready is sampled high
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero
);

    localparam logic [5:0] OP_ADDU  = 6'b001001;
    localparam logic [5:0] OP_SUBU  = 6'b001010;
    localparam logic [5:0] OP_SLL   = 6'b100001;
    localparam logic [5:0] OP_SLLV  = 6'b110101;
    localparam logic [5:0] OP_SLTI  = 6'b101010;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] opa_q, opa_d;      // multiplicand or divisor
    logic [WIDTH-1:0] hi_q, hi_d;        // partial product high / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;        // multiplier bits / dividend-quotient shift
    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;

    logic [WIDTH-1:0] alu_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_rsh;
    logic [WIDTH-1:0] div_rsub;
    logic             div_qbit;
    logic [WIDTH-1:0] div_hi, div_lo;

    // Single-cycle results, computed straight from the request at acceptance
    always_comb begin
        alu_lo = '0;
        case (funct)
            OP_ADDU: alu_lo = data1 + data2;
            OP_SUBU: alu_lo = data1 - data2;
            OP_SLL:  alu_lo = data1 << shamt;
            OP_SLLV: alu_lo = data1 << data2[SHW-1:0];
            OP_SLTI: alu_lo = WIDTH'(data1 < data2);
            default: alu_lo = '0;
        endcase
    end

    // One shift-add step: add multiplicand when multiplier LSB is set, then shift right
    assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opa_q} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // One restoring-divide step; a zero divisor naturally yields all-ones
    // quotient and the dividend as remainder
    assign div_rsh  = {hi_q, lo_q[WIDTH-1]};
    assign div_qbit = (div_rsh >= {1'b0, opa_q});
    assign div_rsub = div_rsh[WIDTH-1:0] - opa_q;
    assign div_hi   = div_qbit ? div_rsub : div_rsh[WIDTH-1:0];
    assign div_lo   = {lo_q[WIDTH-2:0], div_qbit};

    // Next-state, datapath and result-register update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        opa_d    = opa_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (funct == OP_MULTU) begin
                        state_d  = S_BUSY;
                        cnt_d    = SHW'(WIDTH - 1);
                        is_div_d = 1'b0;
                        opa_d    = data1;
                        hi_d     = '0;
                        lo_d     = data2;
                    end else if (funct == OP_DIVU) begin
                        state_d  = S_BUSY;
                        cnt_d    = SHW'(WIDTH - 1);
                        is_div_d = 1'b1;
                        opa_d    = data2;
                        hi_d     = '0;
                        lo_d     = data1;
                    end else begin
                        state_d  = S_DONE;
                        res_lo_d = alu_lo;
                        res_hi_d = '0;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = is_div_q ? div_hi : mul_hi;
                lo_d  = is_div_q ? div_lo : mul_lo;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_lo_d = lo_d;
                    res_hi_d = hi_d;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            opa_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_lo_q <= '0;
            res_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            opa_q    <= opa_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign zero      = out_valid && (res_lo_q == '0);

endmodule
